// File: rtl/alu_nbit_seq.sv
// Registered, valid/ready-handshaked N-bit MIPS-style ALU.
// Optional iterative shift-add multiply (code 1000) is built only when ALU_MUL_EN is defined.
module alu_nbit_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] MUL_BUSY = 1'b1;

    logic [0:0]       state_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;
    logic             carry_reg;
    logic             overflow_reg;
    logic             illegal_reg;

    logic             accept;
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             carry_into_msb;
    logic             add_ovf;
    logic [WIDTH-1:0] res_next;
    logic             carry_next;
    logic             overflow_next;
    logic             illegal_next;

`ifdef ALU_MUL_EN
    localparam int MUL_CYCLES = WIDTH;
    localparam int CW = $clog2(MUL_CYCLES + 1);

    logic             is_mul;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] acc_next;

    assign is_mul   = (alu_ctl == 4'b1000);
    // Only the low WIDTH bits of the product are kept, so the accumulator wraps.
    assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
`endif

    assign in_ready = (state_reg == IDLE) && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;

    // ainv/bneg act directly on the operands; bneg doubles as the adder carry-in.
    assign a_eff = alu_ctl[3] ? ~a : a;
    assign b_eff = alu_ctl[2] ? ~b : b;
    assign sum   = {1'b0, a_eff} + {1'b0, b_eff} + {{WIDTH{1'b0}}, alu_ctl[2]};

    assign carry_into_msb = a_eff[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1];
    assign add_ovf        = carry_into_msb ^ sum[WIDTH];

    always_comb begin
        res_next      = '0;
        carry_next    = 1'b0;
        overflow_next = 1'b0;
        illegal_next  = 1'b0;
        case (alu_ctl)
            4'b0000, 4'b1100: res_next = a_eff & b_eff;
            4'b0001:          res_next = a_eff | b_eff;
            4'b0010, 4'b0110: begin
                res_next      = sum[WIDTH-1:0];
                carry_next    = sum[WIDTH];
                overflow_next = add_ovf;
            end
            4'b0111:          res_next = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
`ifdef ALU_MUL_EN
            4'b1000:          res_next = '0;
`endif
            default:          illegal_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            carry_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
            illegal_reg   <= 1'b0;
`ifdef ALU_MUL_EN
            acc_reg       <= '0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            count_reg     <= '0;
`endif
        end else begin
            if (accept) begin
`ifdef ALU_MUL_EN
                if (is_mul) begin
                    state_reg     <= MUL_BUSY;
                    acc_reg       <= '0;
                    mcand_reg     <= a;
                    mplier_reg    <= b;
                    count_reg     <= '0;
                    out_valid_reg <= 1'b0;
                end else
`endif
                begin
                    out_valid_reg <= 1'b1;
                    result_reg    <= res_next;
                    zero_reg      <= (res_next == '0);
                    carry_reg     <= carry_next;
                    overflow_reg  <= overflow_next;
                    illegal_reg   <= illegal_next;
                end
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
`ifdef ALU_MUL_EN
            if (state_reg == MUL_BUSY) begin
                acc_reg    <= acc_next;
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                count_reg  <= count_reg + 1'b1;
                if (count_reg == CW'(MUL_CYCLES - 1)) begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b1;
                    result_reg    <= acc_next;
                    zero_reg      <= (acc_next == '0);
                    carry_reg     <= 1'b0;
                    overflow_reg  <= 1'b0;
                    illegal_reg   <= 1'b0;
                end
            end
`endif
        end
    end

    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign zero      = zero_reg;
    assign carry     = carry_reg;
    assign overflow  = overflow_reg;
    assign illegal   = illegal_reg;

endmodule

// File: tb/tb_alu_nbit_seq.sv
// Directed self-checking bench for alu_nbit_seq at WIDTH=8.
// MUL scenarios run when ALU_MUL_EN is defined; otherwise code 1000 is checked as illegal.
module tb_alu_nbit_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] alu_ctl;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       zero;
    logic       carry;
    logic       overflow;
    logic       illegal;

    int pass_cnt  = 0;
    int total_cnt = 0;

    alu_nbit_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alu_ctl   (alu_ctl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op, wait (bounded) for acceptance, then drop in_valid.
    task automatic issue(input logic [3:0] ctl, input logic [7:0] av, input logic [7:0] bv);
        int n;
        alu_ctl  = ctl;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            step();
            n++;
        end
        if (!in_ready) begin
            total_cnt++;
            $display("FAIL issue_timeout: in_ready=%0b required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        $display("op ctl=%b a=%h b=%h -> result=%h z=%0b c=%0b v=%0b ill=%0b valid=%0b",
                 ctl, av, bv, result, zero, carry, overflow, illegal, out_valid);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; alu_ctl = '0;
        step(); step();
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({out_valid, result, zero, carry, overflow, illegal} !== 13'h0)
            $display("FAIL reset_outputs: got v=%0b r=%h z=%0b c=%0b o=%0b i=%0b required all 0",
                     out_valid, result, zero, carry, overflow, illegal);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b required 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        issue(4'b0010, 8'h7F, 8'h01);
        total_cnt++;
        if ({out_valid, result, overflow, carry, zero, illegal} !== {1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0})
            $display("FAIL add_7f_01: got v=%0b r=%h o=%0b c=%0b z=%0b i=%0b required v=1 r=80 o=1 c=0 z=0 i=0",
                     out_valid, result, overflow, carry, zero, illegal);
        else pass_cnt++;
    endtask

    task automatic test_sub_slt();
        issue(4'b0110, 8'h05, 8'h05);
        total_cnt++;
        if ({result, zero, carry, overflow} !== {8'h00, 1'b1, 1'b1, 1'b0})
            $display("FAIL sub_eq: got r=%h z=%0b c=%0b o=%0b required r=00 z=1 c=1 o=0",
                     result, zero, carry, overflow);
        else pass_cnt++;
        issue(4'b0110, 8'h80, 8'h01);
        total_cnt++;
        if ({result, carry, overflow} !== {8'h7F, 1'b1, 1'b1})
            $display("FAIL sub_ovf: got r=%h c=%0b o=%0b required r=7f c=1 o=1", result, carry, overflow);
        else pass_cnt++;
        issue(4'b0111, 8'h80, 8'h01);
        total_cnt++;
        if ({result, zero, carry, overflow} !== {8'h01, 1'b0, 1'b0, 1'b0})
            $display("FAIL slt_neg: got r=%h z=%0b c=%0b o=%0b required r=01 z=0 c=0 o=0",
                     result, zero, carry, overflow);
        else pass_cnt++;
        issue(4'b0111, 8'h7F, 8'h80);
        total_cnt++;
        if ({result, zero, carry, overflow} !== {8'h00, 1'b1, 1'b0, 1'b0})
            $display("FAIL slt_ovf_fix: got r=%h z=%0b c=%0b o=%0b required r=00 z=1 c=0 o=0",
                     result, zero, carry, overflow);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        logic [3:0] ctls [3];
        logic [7:0] exps [3];
        ctls[0] = 4'b0000; exps[0] = 8'h30;
        ctls[1] = 4'b0001; exps[1] = 8'hFC;
        ctls[2] = 4'b1100; exps[2] = 8'h03;
        out_ready = 1'b1;
        a = 8'hF0; b = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            alu_ctl = ctls[i]; in_valid = 1'b1;
            #1;
            total_cnt++;
            if (in_ready !== 1'b1) $display("FAIL stream_in_ready_%0d: got %0b required 1", i, in_ready);
            else pass_cnt++;
            step();
            $display("stream op %0d ctl=%b -> result=%h valid=%0b", i, ctls[i], result, out_valid);
            total_cnt++;
            if ({out_valid, result} !== {1'b1, exps[i]})
                $display("FAIL stream_result_%0d: got v=%0b r=%h required v=1 r=%h", i, out_valid, result, exps[i]);
            else pass_cnt++;
        end
        in_valid = 1'b0;
        step();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL stream_drain: out_valid got %0b required 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        issue(4'b0010, 8'h10, 8'h20);
        alu_ctl = 4'b0001; a = 8'h01; b = 8'h02; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total_cnt++;
            if ({in_ready, out_valid, result} !== {1'b0, 1'b1, 8'h30})
                $display("FAIL stall_%0d: got rdy=%0b v=%0b r=%h required rdy=0 v=1 r=30",
                         i, in_ready, out_valid, result);
            else pass_cnt++;
            step();
            $display("stall cycle %0d result=%h in_ready=%0b", i, result, in_ready);
        end
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL release_in_ready: got %0b required 1", in_ready);
        else pass_cnt++;
        step();
        in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, result} !== {1'b1, 8'h03})
            $display("FAIL release_next: got v=%0b r=%h required v=1 r=03", out_valid, result);
        else pass_cnt++;
        step();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        issue(4'b0101, 8'hFF, 8'hFF);
        total_cnt++;
        if ({out_valid, result, zero, carry, overflow, illegal} !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1})
            $display("FAIL illegal_0101: got v=%0b r=%h z=%0b c=%0b o=%0b i=%0b required v=1 r=00 z=1 c=0 o=0 i=1",
                     out_valid, result, zero, carry, overflow, illegal);
        else pass_cnt++;
        issue(4'b0001, 8'h00, 8'h00);
        total_cnt++;
        if ({illegal, zero} !== 2'b01) $display("FAIL illegal_clear: got i=%0b z=%0b required i=0 z=1", illegal, zero);
        else pass_cnt++;
`ifndef ALU_MUL_EN
        issue(4'b1000, 8'h0C, 8'h0B);
        total_cnt++;
        if ({out_valid, result, zero, illegal} !== {1'b1, 8'h00, 1'b1, 1'b1})
            $display("FAIL illegal_1000: got v=%0b r=%h z=%0b i=%0b required v=1 r=00 z=1 i=1",
                     out_valid, result, zero, illegal);
        else pass_cnt++;
`endif
        step();
    endtask

`ifdef ALU_MUL_EN
    task automatic test_mul();
        logic [7:0] ma [2];
        logic [7:0] mb [2];
        logic [7:0] mexp [2];
        ma[0] = 8'h0C; mb[0] = 8'h0B; mexp[0] = 8'h84;
        ma[1] = 8'h10; mb[1] = 8'h10; mexp[1] = 8'h00;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            issue(4'b1000, ma[k], mb[k]);
            for (int i = 0; i < 8; i++) begin
                total_cnt++;
                if ({in_ready, out_valid} !== 2'b00)
                    $display("FAIL mul%0d_busy_%0d: got rdy=%0b v=%0b required rdy=0 v=0", k, i, in_ready, out_valid);
                else pass_cnt++;
                step();
            end
            $display("mul %h*%h -> result=%h z=%0b valid=%0b", ma[k], mb[k], result, zero, out_valid);
            total_cnt++;
            if ({out_valid, result, zero, illegal} !== {1'b1, mexp[k], mexp[k] == 8'h00, 1'b0})
                $display("FAIL mul%0d_result: got v=%0b r=%h z=%0b i=%0b required v=1 r=%h z=%0b i=0",
                         k, out_valid, result, zero, illegal, mexp[k], mexp[k] == 8'h00);
            else pass_cnt++;
            step();
        end
        issue(4'b1000, 8'h03, 8'h05);
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL mul_abort_ready: got %0b required 1", in_ready);
        else pass_cnt++;
        for (int i = 0; i < 12; i++) begin
            total_cnt++;
            if (out_valid !== 1'b0) $display("FAIL mul_abort_valid_%0d: got %0b required 0", i, out_valid);
            else pass_cnt++;
            step();
        end
        $display("mul abort: out_valid=%0b in_ready=%0b", out_valid, in_ready);
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_sub_slt();
        test_stream();
        test_back_to_back();
        test_illegal();
`ifdef ALU_MUL_EN
        test_mul();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/alu_nbit_seq.md
Name: alu_nbit_seq

Overview:
- Parametrised N-bit ALU that replaces the ripple chain of 1-bit ALU slices with a registered, handshaked execution unit.
- Supports the full MIPS-style 4-bit ALU control set, including SLT with overflow correction, plus an optional iterative shift-add multiply.
- Sits between operand fetch and writeback. Input and output are valid/ready streams, so the datapath can stall.

Parameters:
- WIDTH, 32, operand/result width in bits (legal values 4..64).
- MUL_CYCLES, WIDTH, iterations of the multiply loop. Fixed equal to WIDTH; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands and control are valid.
- in_ready  output  1  block can accept an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- alu_ctl  input  4  {ainv, bneg, op[1:0]}.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0.
- carry  output  1  carry out of the MSB (add/sub only, else 0).
- overflow  output  1  signed overflow (add/sub only, else 0).
- illegal  output  1  alu_ctl was not a supported code.

Behaviour:
- Encodings:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB (a + ~b + 1)
  - 0111 SLT (signed)
  - 1100 NOR (~a & ~b)
  - 1000 MUL (only with ALU_MUL_EN)
  - All other codes are illegal.
- Handshake:
  - An operation is accepted when in_valid && in_ready.
  - The output transfers when out_valid && out_ready.
  - While out_valid && !out_ready, result and flags hold stable.
- in_ready = (state == IDLE) && (!out_valid || out_ready). Back-to-back single-cycle ops therefore reach full throughput.
- FSM has states IDLE and MUL_BUSY.
  - IDLE, accepting a non-MUL op: result and flags are registered at the next edge; out_valid = 1 the cycle after accept (latency 1). State stays IDLE.
  - IDLE, accepting MUL: latch a, b, clear the accumulator, counter = 0, go to MUL_BUSY. in_ready = 0 while busy.
  - MUL_BUSY, each cycle: if multiplier bit0 is set, acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, counter++.
  - MUL_BUSY, after WIDTH iterations: result = acc[WIDTH-1:0] (low half, wrap-around), out_valid = 1, return to IDLE. Latency is WIDTH+1 cycles from accept to out_valid.
- Arithmetic:
  - One (WIDTH+1)-bit adder: sum = A' + B' + bneg.
  - carry = sum[WIDTH].
  - overflow = carry into MSB XOR carry out of MSB.
- SLT:
  - result = {WIDTH-1 zeros, sub[WIDTH-1] ^ ovf_sub}.
  - carry = 0 and overflow = 0 for SLT.
- zero is computed from the final registered result for every op, including MUL.
- Illegal code: result = 0, zero = 1, carry = 0, overflow = 0, illegal = 1. It is still a normal 1-cycle completion.
- Reset:
  - out_valid = 0, result = 0, zero = 0, carry = 0, overflow = 0, illegal = 0.
  - State = IDLE, counter = 0.
  - in_ready is 1 in the first cycle after reset.
  - rst during MUL_BUSY aborts the multiply; no result is produced.
- Simultaneous events:
  - Output drain and new accept in the same cycle: the new result overwrites the register and out_valid stays 1.
  - If out_valid is set and out_ready = 0, no accept occurs.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: the MUL code 1000 and the MUL_BUSY state are built as described.
- Undefined:
  - No multiplier logic and no counter.
  - 1000 is treated as illegal (1-cycle, illegal = 1, result = 0).
  - The FSM reduces to IDLE only.

Test Plan (WIDTH=8):
- ADD a=0x7F, b=0x01, out_ready=1 -> next cycle result=0x80, overflow=1, carry=0, zero=0.
- SUB a=0x05, b=0x05 -> result=0x00, zero=1, carry=1, overflow=0. Also SLT a=0x80, b=0x01 -> result=0x01. SLT a=0x7F, b=0x80 -> result=0x00 (overflow corrected).
- Stream AND, OR, NOR on 3 consecutive cycles with out_ready=1 -> one result per cycle; in_ready stays 1 throughout.
- Complete ADD then hold out_ready=0 for 4 cycles -> result stable, in_ready=0; out_ready=1 releases it and accepts the next op in the same cycle.
- ALU_MUL_EN defined: MUL a=0x0C, b=0x0B -> in_ready=0 for 8 cycles, out_valid at cycle 9, result=0x84. MUL 0x10 x 0x10 -> 0x00, zero=1. Assert rst mid-multiply -> out_valid never rises, in_ready=1 after reset.
- Illegal code 0101, and 1000 without the macro -> 1-cycle completion with illegal=1, result=0.
